// File: rtl/scalar_muldiv_unit_pkg.sv
// Shared constants for the scalar multiply/divide unit: op encoding, FSM states, default widths.
package scalar_muldiv_unit_pkg;
  localparam int DEF_BIT_NUMBER  = 32;
  localparam int DEF_ADDR_NUMBER = 5;

  localparam logic [1:0] OP_MULU_LO = 2'b00;
  localparam logic [1:0] OP_MULU_HI = 2'b01;
  localparam logic [1:0] OP_DIVU    = 2'b10;
  localparam logic [1:0] OP_REMU    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/scalar_muldiv_unit_if.sv
// Issue-side request / register-file-side response bundle of the muldiv unit.
interface scalar_muldiv_unit_if
  import scalar_muldiv_unit_pkg::*;
#(
  parameter int BIT_NUMBER  = DEF_BIT_NUMBER,
  parameter int ADDR_NUMBER = DEF_ADDR_NUMBER
);
  logic                   start;
  logic [1:0]             op;
  logic [BIT_NUMBER-1:0]  operand_a;
  logic [BIT_NUMBER-1:0]  operand_b;
  logic [ADDR_NUMBER-1:0] dest_addr_in;
  logic                   flush;
  logic                   busy;
  logic                   result_valid;
  logic [BIT_NUMBER-1:0]  result;
  logic [ADDR_NUMBER-1:0] dest_addr_out;
  logic                   write_enable_out;
  logic                   div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, dest_addr_in, flush,
    input  busy, result_valid, result, dest_addr_out, write_enable_out, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, dest_addr_in, flush,
    output busy, result_valid, result, dest_addr_out, write_enable_out, div_by_zero
  );
endinterface

// File: rtl/scalar_muldiv_unit_muldiv_step.sv
// One iteration of the datapath: shift-add multiply step or restoring divide step.
module muldiv_step
  import scalar_muldiv_unit_pkg::*;
#(
  parameter int BIT_NUMBER = DEF_BIT_NUMBER
) (
  input  logic                  i_is_div,
  input  logic [BIT_NUMBER:0]   i_acc,
  input  logic [BIT_NUMBER-1:0] i_lo,
  input  logic [BIT_NUMBER-1:0] i_b,
  output logic [BIT_NUMBER:0]   o_acc,
  output logic [BIT_NUMBER-1:0] o_lo
);
  logic [BIT_NUMBER:0] w_sum;
  logic [BIT_NUMBER:0] w_shl;
  logic [BIT_NUMBER:0] w_diff;

  // Multiply: {acc,lo} is the product with the multiplier consumed from lo's LSB.
  assign w_sum  = i_lo[0] ? (i_acc + {1'b0, i_b}) : i_acc;
  // Divide: acc is the partial remainder, lo shifts dividend out / quotient in.
  assign w_shl  = {i_acc[BIT_NUMBER-1:0], i_lo[BIT_NUMBER-1]};
  assign w_diff = w_shl - {1'b0, i_b};

  always_comb begin
    o_acc = {1'b0, w_sum[BIT_NUMBER:1]};
    o_lo  = {w_sum[0], i_lo[BIT_NUMBER-1:1]};
    if (i_is_div) begin
      if (!w_diff[BIT_NUMBER]) begin
        o_acc = w_diff;
        o_lo  = {i_lo[BIT_NUMBER-2:0], 1'b1};
      end else begin
        o_acc = w_shl;
        o_lo  = {i_lo[BIT_NUMBER-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/scalar_muldiv_unit.sv
// Iterative unsigned multiply/divide unit, one bit per cycle, feeding the register file write port.
module scalar_muldiv_unit
  import scalar_muldiv_unit_pkg::*;
#(
  parameter int BIT_NUMBER  = DEF_BIT_NUMBER,
  parameter int ADDR_NUMBER = DEF_ADDR_NUMBER
) (
  input  logic               clk,
  input  logic               reset,
  scalar_muldiv_unit_if.slave bus
);
  localparam int            CW   = $clog2(BIT_NUMBER) + 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_NUMBER - 1);

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [1:0]             r_op;
  logic [BIT_NUMBER:0]    r_acc;
  logic [BIT_NUMBER-1:0]  r_lo, r_b, r_result;
  logic [ADDR_NUMBER-1:0] r_dest_q, r_dest_out;
  logic                   r_dbz;

  logic [BIT_NUMBER:0]    w_acc_nxt;
  logic [BIT_NUMBER-1:0]  w_lo_nxt, w_fin_res;
  logic                   w_accept, w_dbz_start, w_calc_last;
  logic                   w_busy, w_valid, w_dbz;

  assign w_dbz_start = bus.op[1] && (bus.operand_b == '0);
  assign w_accept    = (r_state == IDLE) && bus.start && !bus.flush;
  assign w_calc_last = (r_state == CALC) && (r_cnt == LAST) && !bus.flush;

  muldiv_step #(.BIT_NUMBER(BIT_NUMBER)) u_step (
    .i_is_div (r_op[1]),
    .i_acc    (r_acc),
    .i_lo     (r_lo),
    .i_b      (r_b),
    .o_acc    (w_acc_nxt),
    .o_lo     (w_lo_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_dbz_start ? DONE : CALC;
      CALC:    if (bus.flush) w_state_nxt = IDLE;
               else if (r_cnt == LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // flush in DONE suppresses the write in the same cycle
  always_comb begin
    w_busy  = (r_state != IDLE);
    w_valid = (r_state == DONE) && !bus.flush;
    w_dbz   = w_valid && r_dbz;
  end

  always_comb begin
    unique case (r_op)
      OP_MULU_LO, OP_DIVU: w_fin_res = w_lo_nxt;
      default:             w_fin_res = w_acc_nxt[BIT_NUMBER-1:0];
    endcase
  end

  // Operand placement: lo holds the multiplier or the dividend, b the multiplicand or divisor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_acc      <= '0;
      r_lo       <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_dest_q   <= '0;
      r_dest_out <= '0;
      r_dbz      <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_op     <= bus.op;
      r_acc    <= '0;
      r_lo     <= bus.op[1] ? bus.operand_a : bus.operand_b;
      r_b      <= bus.op[1] ? bus.operand_b : bus.operand_a;
      r_dest_q <= bus.dest_addr_in;
      if (w_dbz_start) begin
        r_result   <= bus.op[0] ? bus.operand_a : '1;
        r_dest_out <= bus.dest_addr_in;
        r_dbz      <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_acc <= w_acc_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_calc_last) begin
        r_result   <= w_fin_res;
        r_dest_out <= r_dest_q;
        r_dbz      <= 1'b0;
      end
    end
  end

  assign bus.busy             = w_busy;
  assign bus.result_valid     = w_valid;
  assign bus.write_enable_out = w_valid;
  assign bus.div_by_zero      = w_dbz;
  assign bus.result           = r_result;
  assign bus.dest_addr_out    = r_dest_out;
endmodule

// File: tb/tb_scalar_muldiv_unit.sv
// Directed plus randomized bench for scalar_muldiv_unit against an arithmetic reference model.
module tb_scalar_muldiv_unit;
  localparam int W = 32;
  localparam int A = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  scalar_muldiv_unit_if #(.BIT_NUMBER(W), .ADDR_NUMBER(A)) bus ();

  scalar_muldiv_unit #(.BIT_NUMBER(W), .ADDR_NUMBER(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called just after a clock edge; start is sampled at the next edge (cycle 0).
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [A-1:0] d, input string tag);
    logic [W-1:0] exp;
    logic         exp_dbz;
    int           lat, cyc;
    bit           seen;
    exp     = model(op, a, b);
    exp_dbz = op[1] && (b == 0);
    lat     = exp_dbz ? 1 : W + 1;
    bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.dest_addr_in = d; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.operand_a = $urandom; bus.operand_b = $urandom;
    bus.dest_addr_in = A'($urandom); bus.op = 2'($urandom);
    cyc = 1; seen = 0;
    while (!seen && cyc <= 40) begin
      check($sformatf("%s.busy@%0d", tag, cyc), 64'(bus.busy), 64'(1));
      if (bus.result_valid) begin
        seen = 1;
        bus.start = 1'b0;
        check($sformatf("%s.lat", tag), 64'(cyc), 64'(lat));
        check($sformatf("%s.res", tag), 64'(bus.result), 64'(exp));
        check($sformatf("%s.dest", tag), 64'(bus.dest_addr_out), 64'(d));
        check($sformatf("%s.dbz", tag), 64'(bus.div_by_zero), 64'(exp_dbz));
        check($sformatf("%s.we", tag), 64'(bus.write_enable_out), 64'(1));
      end else begin
        bus.start = 1'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $error("FAIL %s.timeout got=no_valid exp=valid_in_cycle_%0d", tag, lat);
    end
    @(posedge clk); #1;
    check($sformatf("%s.idle_busy", tag), 64'(bus.busy), 64'(0));
    check($sformatf("%s.idle_valid", tag), 64'(bus.result_valid), 64'(0));
  endtask

  task automatic no_valid_for(input int n, input string tag);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.result_valid || bus.write_enable_out) hits++;
      @(posedge clk); #1;
    end
    check(tag, 64'(hits), 64'(0));
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    reset = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
    bus.operand_a = '0; bus.operand_b = '0; bus.dest_addr_in = '0;
    #12;
    check("rst.busy",  64'(bus.busy), 64'(0));
    check("rst.valid", 64'(bus.result_valid), 64'(0));
    check("rst.we",    64'(bus.write_enable_out), 64'(0));
    check("rst.res",   64'(bus.result), 64'(0));
    check("rst.dest",  64'(bus.dest_addr_out), 64'(0));
    check("rst.dbz",   64'(bus.div_by_zero), 64'(0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 32'd7, 32'd6, 5'd3, "mul7x6");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, "mulff_lo");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, "mulff_hi");
    run_op(2'b10, 32'd100, 32'd7, 5'd4, "div100_7");
    run_op(2'b11, 32'd100, 32'd7, 5'd5, "rem100_7");
    run_op(2'b10, 32'd5, 32'd0, 5'd6, "div5_0");
    run_op(2'b11, 32'd5, 32'd0, 5'd7, "rem5_0");
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 5'd31, "divmax_1");

    // flush in cycle 10 of a multiply, then an immediate restart
    bus.op = 2'b00; bus.operand_a = 32'd123; bus.operand_b = 32'd456; bus.dest_addr_in = 5'd1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    no_valid_for(9, "flush.pre_valid");
    bus.flush = 1'b1;
    check("flush.c10_valid", 64'(bus.result_valid), 64'(0));
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush.c11_busy", 64'(bus.busy), 64'(0));
    check("flush.c11_valid", 64'(bus.result_valid), 64'(0));
    run_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 5'd12, "after_flush");

    // flush beats start in IDLE
    bus.op = 2'b00; bus.operand_a = 32'd3; bus.operand_b = 32'd3; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("idleflush.busy", 64'(bus.busy), 64'(0));
    no_valid_for(36, "idleflush.no_valid");

    // flush in the DONE cycle of a divide-by-zero suppresses the write
    bus.op = 2'b10; bus.operand_a = 32'd9; bus.operand_b = 32'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("doneflush.valid_pre", 64'(bus.result_valid), 64'(1));
    bus.flush = 1'b1; #1;
    check("doneflush.valid", 64'(bus.result_valid), 64'(0));
    check("doneflush.we", 64'(bus.write_enable_out), 64'(0));
    check("doneflush.dbz", 64'(bus.div_by_zero), 64'(0));
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("doneflush.busy", 64'(bus.busy), 64'(0));

    // async reset between edges in cycle 15
    run_op(2'b00, 32'd11, 32'd13, 5'd21, "pre_reset");
    bus.op = 2'b00; bus.operand_a = 32'd77; bus.operand_b = 32'd88; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    #2 reset = 1'b1; #1;
    check("midrst.busy", 64'(bus.busy), 64'(0));
    check("midrst.res", 64'(bus.result), 64'(0));
    check("midrst.dest", 64'(bus.dest_addr_out), 64'(0));
    check("midrst.valid", 64'(bus.result_valid), 64'(0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    no_valid_for(40, "midrst.no_valid");

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom_range(0, 1) ? $urandom : W'($urandom_range(0, 1000));
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, A'($urandom), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
